key_loader: RTL

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/key_loader.sv
// key_loader: serial key loader with even-parity check.
// Shifts KEY_W data bits (LSB first) plus one parity bit, checks parity for
// one cycle, then presents the key to the downstream locked FSM. An all-zero
// key_out is the locked default whenever no valid key is held.
//
// state | meaning
// IDLE  | no load in progress, waiting for key_start
// SHIFT | collecting data bits, then the parity bit; idle timer running
// CHECK | single-cycle parity evaluation of the collected bits
// HOLD  | parity-checked key presented on key_out with key_valid=1
// ERR   | parity failure or inter-bit timeout; key_out forced to zero
module key_loader #(
  parameter int KEY_W = 8,
  parameter int TMO   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sin,
  input  logic             key_sin_vld,
  input  logic             key_clr,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TMR_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(KEY_W);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TMO);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [KEY_W-1:0] shreg, shreg_n;
  logic             par, par_n;
  logic [KEY_W-1:0] key_out_n;
  logic             key_valid_n;

  // State and datapath registers; reset forces the locked default at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tmr       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tmr       <= tmr_n;
      shreg     <= shreg_n;
      par       <= par_n;
      key_out   <= key_out_n;
      key_valid <= key_valid_n;
    end
  end

  // Next-state and next-datapath logic; key_clr outranks everything else.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tmr_n       = tmr;
    shreg_n     = shreg;
    par_n       = par;
    key_out_n   = key_out;
    key_valid_n = key_valid;

    if (key_clr) begin
      state_n     = IDLE;
      cnt_n       = '0;
      tmr_n       = '0;
      shreg_n     = '0;
      par_n       = 1'b0;
      key_out_n   = '0;
      key_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE, HOLD, ERR: begin
          // key_valid and key_out are untouched here so a reload from HOLD
          // keeps presenting the old key until the new one passes.
          if (key_start) begin
            state_n = SHIFT;
            cnt_n   = '0;
            tmr_n   = '0;
            shreg_n = '0;
            par_n   = 1'b0;
          end
        end
        SHIFT: begin
          if (key_start) begin
            cnt_n   = '0;
            tmr_n   = '0;
            shreg_n = '0;
            par_n   = 1'b0;
          end else if (key_sin_vld) begin
            tmr_n = '0;
            if (cnt == CNT_MAX) begin
              par_n   = key_sin;
              state_n = CHECK;
            end else begin
              shreg_n = shreg | (KEY_W'(key_sin) << cnt);
              cnt_n   = cnt + 1'b1;
            end
          end else begin
            if (tmr != TMR_MAX) tmr_n = tmr + 1'b1;
            if (tmr >= TMR_LAST) begin
              // A stalled load (fresh or reload) is treated as a failed load:
              // any previously held key is withdrawn.
              state_n     = ERR;
              key_out_n   = '0;
              key_valid_n = 1'b0;
            end
          end
        end
        CHECK: begin
          if ((^shreg ^ par) == 1'b0) begin
            state_n     = HOLD;
            key_out_n   = shreg;
            key_valid_n = 1'b1;
          end else begin
            state_n     = ERR;
            key_out_n   = '0;
            key_valid_n = 1'b0;
          end
        end
        default: begin
          state_n     = IDLE;
          key_out_n   = '0;
          key_valid_n = 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT) || (state == CHECK);
  assign err  = (state == ERR);

endmodule
